// File: rtl/password_lock.sv
// Serial-entry password lock with failed-attempt lockout.
// Inputs are synchronised and edge-detected in the clk domain.
module password_lock #(
    parameter int                PW_LEN         = 16,
    parameter logic [PW_LEN-1:0] GOOD_PASSWORD  = 16'h39C3,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 1024,
    parameter int                BLINK_BIT      = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic d,
    input  logic commit,
    output logic led_ok,
    output logic led_blink,
    output logic led_last,
    output logic led_locked
);

    localparam int CNT_W = $clog2(PW_LEN + 1);
    localparam int LT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PW_LEN);
    localparam logic [LT_W-1:0]  LT_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [4:0]       FAIL_MAX = 5'(MAX_FAILS);

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t              state;
    logic [PW_LEN-1:0]   sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          fails;
    logic [LT_W-1:0]     lock_timer;
    logic [BLINK_BIT:0]  blink_cnt;

    // s1 = [0], s2 = [1], s3 = [2]; d only needs the two-flop level
    logic [2:0] shift_q;
    logic [2:0] commit_q;
    logic [1:0] d_q;

    logic       shift_ev;
    logic       commit_ev;
    logic       bit_in;
    logic       pass;
    logic [4:0] fails_inc;

    assign shift_ev  = shift_q[1] & ~shift_q[2];
    assign commit_ev = commit_q[1] & ~commit_q[2];
    assign bit_in    = d_q[1];
    assign pass      = (bit_cnt == CNT_FULL) && (sr == GOOD_PASSWORD);
    assign fails_inc = {1'b0, fails} + 5'd1;

    // Synchronise the asynchronous buttons and data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            commit_q <= '0;
            d_q      <= '0;
        end else begin
            shift_q  <= {shift_q[1:0], shift};
            commit_q <= {commit_q[1:0], commit};
            d_q      <= {d_q[0], d};
        end
    end

    // Lock state machine, entry shift register and attempt tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTRY;
            sr         <= '0;
            bit_cnt    <= '0;
            fails      <= '0;
            lock_timer <= '0;
            blink_cnt  <= '0;
            led_last   <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            case (state)
                ENTRY: begin
                    if (commit_ev) begin
                        sr      <= '0;
                        bit_cnt <= '0;
                        if (pass) begin
                            state <= UNLOCKED;
                            fails <= '0;
                        end else if (fails_inc < FAIL_MAX) begin
                            fails <= fails + 1'b1;
                        end else begin
                            state      <= LOCKED;
                            lock_timer <= LT_LOAD;
                            fails      <= '0;
                        end
                    end else if (shift_ev) begin
                        sr       <= (sr << 1) | PW_LEN'(bit_in);
                        led_last <= bit_in;
                        if (bit_cnt != CNT_FULL) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                UNLOCKED: begin
                    if (commit_ev) begin
                        state   <= ENTRY;
                        sr      <= '0;
                        bit_cnt <= '0;
                        fails   <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_timer == '0) begin
                        state <= ENTRY;
                    end else begin
                        lock_timer <= lock_timer - 1'b1;
                    end
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

    assign led_ok     = (state == UNLOCKED);
    assign led_locked = (state == LOCKED);
    assign led_blink  = led_ok & blink_cnt[BLINK_BIT];

endmodule

// File: tb/tb_password_lock.sv
// Bench for password_lock: vector table with an expectation queue,
// plus hand-written lockout, simultaneous-event, blink and reset cases.
module tb_password_lock;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic shift = 1'b0;
    logic d = 1'b0;
    logic commit = 1'b0;
    logic led_ok;
    logic led_blink;
    logic led_last;
    logic led_locked;

    int errors = 0;
    int checks = 0;

    password_lock #(
        .PW_LEN(16),
        .GOOD_PASSWORD(16'h39C3),
        .MAX_FAILS(3),
        .LOCKOUT_CYCLES(64),
        .BLINK_BIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .shift(shift),
        .d(d),
        .commit(commit),
        .led_ok(led_ok),
        .led_blink(led_blink),
        .led_last(led_last),
        .led_locked(led_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic        ok;
        logic        lk;
        logic        last;
    } vec_t;

    typedef struct {
        string name;
        logic  ok;
        logic  lk;
        logic  last;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    // Length of the most recent contiguous led_locked run
    int lk_run = 0;
    int lk_len = 0;
    always @(negedge clk) begin
        if (led_locked) begin
            lk_run = lk_run + 1;
        end else begin
            if (lk_run != 0) lk_len = lk_run;
            lk_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        d = b;
        tick(2);
        shift = 1'b1;
        tick(3);
        shift = 1'b0;
        tick(3);
    endtask

    task automatic enter(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i]);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".ok"}, led_ok, e.ok);
            chk({e.name, ".locked"}, led_locked, e.lk);
            chk({e.name, ".last"}, led_last, e.last);
        end
    endtask

    task automatic do_commit(input string name, input logic ok,
                             input logic lk, input logic last);
        sb.push_back('{name, ok, lk, last});
        commit = 1'b1;
        tick(3);
        check_pop();
        commit = 1'b0;
        tick(3);
    endtask

    initial begin
        logic s[48];
        int   i0;
        int   bad;
        int   w;

        vecs[0]  = '{32'h39C3,  16, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h0,      0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'h1CE1,  15, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h1,      1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h39C3,  16, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h0,      0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'hA39C3, 20, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h0,      0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h1234,  16, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFF,  16, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h0000,  16, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset.ok", led_ok, 1'b0);
        chk("reset.blink", led_blink, 1'b0);
        chk("reset.last", led_last, 1'b0);
        chk("reset.locked", led_locked, 1'b0);

        for (int v = 0; v < 11; v++) begin
            enter(vecs[v].bits, vecs[v].n);
            do_commit($sformatf("vec%0d", v), vecs[v].ok,
                      vecs[v].lk, vecs[v].last);
        end

        // Lockout: shifts and a commit must be ignored
        enter(32'h5, 3);
        commit = 1'b1;
        tick(3);
        commit = 1'b0;
        tick(3);
        chk("lockout.held", led_locked, 1'b1);
        chk("lockout.last_held", led_last, 1'b0);
        chk("lockout.ok", led_ok, 1'b0);

        w = 0;
        while (led_locked && w < 200) begin
            tick(1);
            w++;
        end
        chk("lockout.release_timeout", 32'(w < 200), 32'd1);
        tick(1);
        chk("lockout.length", lk_len, 64);

        enter(32'h39C3, 16);
        do_commit("after_lock", 1'b1, 1'b0, 1'b1);
        do_commit("relock1", 1'b0, 1'b0, 1'b1);

        // Shift and commit events in the same cycle
        enter(32'h39C3, 16);
        d = 1'b0;
        tick(2);
        sb.push_back('{"simul", 1'b1, 1'b0, 1'b1});
        shift = 1'b1;
        commit = 1'b1;
        tick(3);
        check_pop();
        shift = 1'b0;
        commit = 1'b0;
        tick(3);

        // Blink must toggle every 8 cycles while unlocked
        for (int k = 0; k < 48; k++) begin
            s[k] = led_blink;
            tick(1);
        end
        i0 = -1;
        for (int k = 1; k < 10; k++) begin
            if (i0 < 0 && s[k] != s[k-1]) i0 = k;
        end
        bad = 0;
        if (i0 < 0) begin
            bad = 1;
        end else begin
            for (int k = i0; k < i0 + 32; k++) begin
                if (s[k] != (s[i0] ^ (((k - i0) / 8) % 2 == 1)))
                    bad++;
            end
        end
        chk("blink.period", bad, 0);

        do_commit("relock2", 1'b0, 1'b0, 1'b1);
        do_commit("empty1", 1'b0, 1'b0, 1'b1);
        do_commit("empty2", 1'b0, 1'b0, 1'b1);
        do_commit("empty3", 1'b0, 1'b1, 1'b1);

        // Reset mid-lockout
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("rst_lock.ok", led_ok, 1'b0);
        chk("rst_lock.blink", led_blink, 1'b0);
        chk("rst_lock.last", led_last, 1'b0);
        chk("rst_lock.locked", led_locked, 1'b0);
        rst = 1'b0;
        tick(3);
        chk("rst_lock.entry", led_locked, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
